imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Host-side writer for the accelerator's instruction memory, which is the write end of the fetch stage's instruction-read interface.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word-aligned byte addresses starting at PC 0.
- Holds the core in reset while loading and releases it once the program is loaded and verified.

Parameters:
- DEPTH, 1024, instruction memory capacity in 32-bit words.
- ADDR_W, 64, byte-address width; matches PC width.
- CNT_W, 11, word-count width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse that begins a load of num_words words.
- num_words  input  CNT_W  number of program words; sampled only on an accepted load_start.
- in_valid  input  1  host word valid.
- in_data  input  32  host instruction word.
- in_ready  output  1  loader can accept a word.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  byte address; always a multiple of 4.
- imem_wdata  output  32  instruction word to write.
- core_reset  output  1  held high to keep the core in reset.
- busy  output  1  a load is in progress.
- done  output  1  load completed successfully (sticky).
- error  output  1  load rejected or failed (sticky).

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, busy=0, done=0, error=0. Internal: word counter=0, state=IDLE.
- FSM states: IDLE, LOAD, CHECK (present only with the optional feature), DRAIN, DONE, ERROR.
- IDLE, DONE, ERROR accepting load_start:
  - If num_words==0 or num_words>DEPTH: go to ERROR with error=1, done=0, core_reset=1.
  - Otherwise: latch num_words, clear the counter, done=0, error=0, core_reset=1, go to LOAD.
- load_start in LOAD, CHECK or DRAIN is ignored.
- LOAD:
  - in_ready=1 and busy=1.
  - A word is accepted on a cycle with in_valid && in_ready.
  - The write is registered. The cycle after acceptance: imem_we=1, imem_wdata=the accepted word, imem_addr=counter*4 (counter value before increment). Latency from handshake to write is one cycle.
  - The counter increments on each acceptance.
  - Back-to-back acceptances produce back-to-back writes.
  - When the accepted word brings the counter to num_words: go to CHECK if the feature is enabled, otherwise DRAIN.
- DRAIN:
  - in_ready=0; imem_we carries the final write. Next cycle go to DONE.
- DONE:
  - done=1, busy=0, core_reset=0.
- ERROR:
  - error=1, busy=0, core_reset=1.
- imem_we is 0 in every cycle that does not follow an acceptance.
- imem_addr holds its last value when imem_we=0.
- Address never wraps. Overflow is impossible because num_words is bounded by DEPTH at start.
- Reset mid-load aborts immediately, forces reset values and discards partial progress. Memory contents already written are not cleared.
- in_valid while in_ready=0 is not accepted, and in_data is not sampled.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit running sum (mod 2^32) of accepted program words is kept. It is cleared on an accepted load_start.
  - After the last program word, state CHECK holds in_ready=1 and accepts exactly one trailer word. The trailer is not written to memory.
  - Trailer equal to the sum: go to DRAIN, then DONE.
  - Trailer not equal: go to ERROR with error=1 and core_reset=1.
  - The last program write still occurs during the first CHECK cycle.
- Without the macro: no CHECK state, no trailer word; LOAD goes straight to DRAIN.

Decomposition:
- Shared package crypto_pkg holds:
  - the loader state enum typedef;
  - constant INSTR_BYTES=4;
  - constants IMEM_DEPTH and PC_WIDTH, reused by the fetch stage.
- One sub-module, loader_checksum: accumulator with clear/add/compare. It is instantiated only under LOADER_CHECKSUM_EN.

Test Plan:
- Nominal load: reset, then load_start with num_words=3; stream 0x00000013, 0x00A00093, 0xFFFFFFFF with in_valid held high. Expect:
  - writes to addresses 0x0, 0x4, 0x8, each one cycle after its handshake;
  - done=1 and core_reset=0 two cycles after the last handshake.
- Backpressure and gaps: num_words=4 with in_valid toggled every other cycle. Expect exactly 4 writes at addresses 0, 4, 8, 0xC with no duplicate or missed writes; busy=1 throughout.
- Bounds:
  - num_words=0 gives error=1, no imem_we, core_reset=1.
  - num_words=DEPTH+1 gives the same.
  - num_words=DEPTH writes the final word at (DEPTH-1)*4 = 0xFFC, then done=1.
- Reset mid-load: after 2 of 5 words, assert reset for one cycle. Expect all outputs at reset values. A following load with num_words=1 writes to address 0 and sets done=1.
- Ignored restart: load_start pulsed mid-LOAD with a new num_words. Expect the original count still governs completion and the address sequence is unchanged.
- Checksum (LOADER_CHECKSUM_EN): words 0x1 and 0x2.
  - Trailer 0x3 gives done=1.
  - Rerun with trailer 0x4 gives error=1 and core_reset=1.
  - In both runs only 2 memory writes occur.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared loader/fetch constants and the loader state encoding.
package crypto_pkg;
  localparam int IMEM_DEPTH  = 1024;
  localparam int PC_WIDTH    = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } loader_state_e;
endpackage

// File: rtl/loader_checksum.sv
// Running 32-bit sum of program words, compared against a host trailer word.
module loader_checksum (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [31:0] i_data,
  input  logic [31:0] i_cmp,
  output logic        o_match
);
  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_sum <= '0;
    else if (i_add)     r_sum <= r_sum + i_data;
  end

  assign o_match = (r_sum == i_cmp);
endmodule

// File: rtl/imem_program_loader.sv
// Streams host words into instruction memory from PC 0 and holds the core in
// reset until the load completes. Define LOADER_CHECKSUM_EN to require a sum trailer.
module imem_program_loader
  import crypto_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = PC_WIDTH,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);
  loader_state_e    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_num;

  logic w_accept, w_idle, w_bad, w_last;
  assign w_accept = in_valid && in_ready;
  assign w_idle   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_bad    = (num_words == '0) || (num_words > CNT_W'(DEPTH));
  assign w_last   = (r_cnt + CNT_W'(1)) == r_num;

`ifdef LOADER_CHECKSUM_EN
  logic w_match;
  loader_checksum u_sum (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_idle && load_start && !w_bad),
    .i_add   (w_accept && (r_state == ST_LOAD)),
    .i_data  (in_data),
    .i_cmp   (in_data),
    .o_match (w_match)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_num      <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (load_start) begin
            done       <= 1'b0;
            core_reset <= 1'b1;
            if (w_bad) begin
              r_state <= ST_ERROR;
              error   <= 1'b1;
            end else begin
              r_state  <= ST_LOAD;
              r_num    <= num_words;
              r_cnt    <= '0;
              error    <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            imem_we    <= 1'b1;
            imem_wdata <= in_data;
            imem_addr  <= ADDR_W'(r_cnt) * ADDR_W'(INSTR_BYTES);
            r_cnt      <= r_cnt + CNT_W'(1);
            if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
              r_state  <= ST_CHECK;
`else
              r_state  <= ST_DRAIN;
              in_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          // The trailer is consumed here and never reaches memory.
          if (w_accept) begin
            in_ready <= 1'b0;
            if (w_match) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_ERROR;
              error   <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
`endif
        ST_DRAIN: begin
          r_state    <= ST_DONE;
          done       <= 1'b1;
          busy       <= 1'b0;
          core_reset <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader; covers the checksum trailer when
// LOADER_CHECKSUM_EN is defined.
module tb_imem_program_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 11;

  logic              clk = 0;
  logic              reset = 1;
  logic              load_start = 0;
  logic [CNT_W-1:0]  num_words = '0;
  logic              in_valid = 0;
  logic [31:0]       in_data = '0;
  logic              in_ready, imem_we, core_reset, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  wr_t         wr_q[$];
  logic [31:0] pat[$];
  logic [31:0] exp_sum;
  int          total = 0;
  int          bad = 0;

  always @(negedge clk) if (imem_we === 1'b1) wr_q.push_back('{imem_addr, imem_wdata});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load(input int n);
    load_start = 1; num_words = n[CNT_W-1:0]; exp_sum = '0;
    tick();
    load_start = 0;
  endtask

  // Sends pat[base..base+n-1]; optionally idles in_valid every other cycle.
  task automatic send_words(input int n, input int base, input bit gaps,
                            output int not_busy, output bit timeout);
    int idx = 0, cyc = 0;
    bit tog = 1, acc;
    not_busy = 0;
    while (idx < n && cyc < 5000) begin
      in_valid = gaps ? tog : 1'b1;
      in_data  = pat[base+idx];
      acc = in_valid && in_ready;
      tick();
      if (acc) begin exp_sum += pat[base+idx]; idx++; end
      if (idx < n && busy !== 1'b1) not_busy++;
      tog = !tog; cyc++;
    end
    in_valid = 0;
    timeout = (idx < n);
  endtask

  task automatic send_trailer(input logic [31:0] v);
    int cyc = 0;
    in_valid = 1; in_data = v;
    while (in_ready !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    tick();
    in_valid = 0;
  endtask

  task automatic complete_load();
`ifdef LOADER_CHECKSUM_EN
    send_trailer(exp_sum);
`endif
    tick();
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, error} !==
        {1'b0, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h cr=%b b=%b dn=%b er=%b",
        in_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, error);
    end
  endtask

  task automatic test_nominal();
    logic [31:0] w[3] = '{32'h00000013, 32'h00A00093, 32'hFFFFFFFF};
    wr_q.delete();
    start_load(3);
    total++;
    if ({in_ready, busy, imem_we} !== 3'b110) begin
      bad++; $display("FAIL nom_start got rdy/busy/we=%b want 110", {in_ready, busy, imem_we});
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = w[i]; exp_sum += w[i];
      tick();
      total++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 64'(i*4), w[i]}) begin
        bad++; $display("FAIL nom_write%0d got we=%b a=%h d=%h want a=%h d=%h",
          i, imem_we, imem_addr, imem_wdata, i*4, w[i]);
      end
    end
    in_valid = 0;
`ifdef LOADER_CHECKSUM_EN
    in_valid = 1; in_data = exp_sum; tick(); in_valid = 0;
`endif
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL nom_done_early got %b want 0", done); end
    tick();
    total++;
    if ({done, core_reset, busy, error} !== 4'b1000) begin
      bad++; $display("FAIL nom_done got done/cr/busy/err=%b want 1000",
        {done, core_reset, busy, error});
    end
    total++;
    if (wr_q.size() != 3) begin bad++; $display("FAIL nom_wr_count got %0d want 3", wr_q.size()); end
  endtask

  task automatic test_backpressure();
    int nb; bit to;
    pat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    wr_q.delete();
    start_load(4);
    send_words(4, 0, 1'b1, nb, to);
    total++;
    if (to || nb != 0) begin bad++; $display("FAIL bp_busy got timeout=%b not_busy=%0d want 0/0", to, nb); end
    complete_load();
    total++;
    if (wr_q.size() != 4 || done !== 1'b1) begin
      bad++; $display("FAIL bp_count got writes=%0d done=%b want 4/1", wr_q.size(), done);
    end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      total++;
      if ({wr_q[i].a, wr_q[i].d} !== {64'(i*4), pat[i]}) begin
        bad++; $display("FAIL bp_write%0d got a=%h d=%h want a=%h d=%h",
          i, wr_q[i].a, wr_q[i].d, i*4, pat[i]);
      end
    end
  endtask

  task automatic test_bounds();
    int nb; bit to;
    int bad_n[2] = '{0, DEPTH+1};
    for (int k = 0; k < 2; k++) begin
      wr_q.delete();
      start_load(bad_n[k]);
      tick(); tick();
      total++;
      if ({error, core_reset, done, busy, in_ready} !== 5'b11000 || wr_q.size() != 0) begin
        bad++; $display("FAIL bound_n%0d got err/cr/dn/busy/rdy=%b writes=%0d want 11000/0",
          bad_n[k], {error, core_reset, done, busy, in_ready}, wr_q.size());
      end
    end
    pat.delete();
    for (int i = 0; i < DEPTH; i++) pat.push_back(32'hA5000000 + 32'(i));
    wr_q.delete();
    start_load(DEPTH);
    send_words(DEPTH, 0, 1'b0, nb, to);
    complete_load();
    total++;
    if (to || wr_q.size() != DEPTH || {done, error, core_reset} !== 3'b100) begin
      bad++; $display("FAIL bound_full got timeout=%b writes=%0d dn/er/cr=%b want 0/%0d/100",
        to, wr_q.size(), {done, error, core_reset}, DEPTH);
    end else begin
      total++;
      if ({wr_q[DEPTH-1].a, wr_q[DEPTH-1].d} !== {64'hFFC, 32'hA50003FF}) begin
        bad++; $display("FAIL bound_last got a=%h d=%h want a=ffc d=a50003ff",
          wr_q[DEPTH-1].a, wr_q[DEPTH-1].d);
      end
    end
  endtask

  task automatic test_reset_midload();
    int nb; bit to;
    pat = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004, 32'hC0DE0005};
    start_load(5);
    send_words(2, 0, 1'b0, nb, to);
    reset = 1; tick(); reset = 0;
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, error} !==
        {1'b0, 1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midreset_values got rdy=%b we=%b a=%h d=%h cr=%b b=%b dn=%b er=%b",
        in_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, done, error);
    end
    wr_q.delete();
    start_load(1);
    send_words(1, 4, 1'b0, nb, to);
    complete_load();
    total++;
    if (wr_q.size() != 1 || done !== 1'b1 || core_reset !== 1'b0) begin
      bad++; $display("FAIL midreset_reload got writes=%0d done=%b cr=%b want 1/1/0",
        wr_q.size(), done, core_reset);
    end else begin
      total++;
      if ({wr_q[0].a, wr_q[0].d} !== {64'h0, 32'hC0DE0005}) begin
        bad++; $display("FAIL midreset_addr got a=%h d=%h want a=0 d=c0de0005", wr_q[0].a, wr_q[0].d);
      end
    end
  endtask

  task automatic test_ignored_restart();
    int nb; bit to;
    pat = '{32'hAAAA0000, 32'hBBBB1111, 32'hCCCC2222};
    wr_q.delete();
    start_load(3);
    send_words(1, 0, 1'b0, nb, to);
    load_start = 1; num_words = 11'd1; tick(); load_start = 0;
    total++;
    if ({busy, in_ready, error, done} !== 4'b1100) begin
      bad++; $display("FAIL restart_ignored got busy/rdy/err/dn=%b want 1100", {busy, in_ready, error, done});
    end
    send_words(2, 1, 1'b0, nb, to);
    complete_load();
    total++;
    if (wr_q.size() != 3 || done !== 1'b1) begin
      bad++; $display("FAIL restart_count got writes=%0d done=%b want 3/1", wr_q.size(), done);
    end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      total++;
      if ({wr_q[i].a, wr_q[i].d} !== {64'(i*4), pat[i]}) begin
        bad++; $display("FAIL restart_write%0d got a=%h d=%h want a=%h d=%h",
          i, wr_q[i].a, wr_q[i].d, i*4, pat[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int nb; bit to;
    logic [31:0] tr[2] = '{32'h3, 32'h4};
    pat = '{32'h1, 32'h2};
    for (int k = 0; k < 2; k++) begin
      wr_q.delete();
      start_load(2);
      send_words(2, 0, 1'b0, nb, to);
      send_trailer(tr[k]);
      tick();
      total++;
      if (k == 0 && {done, error, core_reset} !== 3'b100) begin
        bad++; $display("FAIL csum_good got dn/er/cr=%b want 100", {done, error, core_reset});
      end
      if (k == 1 && {done, error, core_reset} !== 3'b011) begin
        bad++; $display("FAIL csum_bad got dn/er/cr=%b want 011", {done, error, core_reset});
      end
      total++;
      if (wr_q.size() != 2) begin
        bad++; $display("FAIL csum_writes%0d got %0d want 2", k, wr_q.size());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_bounds();
    test_reset_midload();
    test_ignored_restart();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
